// File: rtl/md_seq_ctrl.sv
// Mul/div sequencing controller at the E stage: launches HI/LO ops,
// holds op/operands for the fixed unit latency and stalls D meanwhile.
module md_seq_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_valid,
   input  logic [3:0]  E_md_op,
   input  logic [31:0] E_a,
   input  logic [31:0] E_b,
   input  logic        D_md_use,
   output logic [3:0]  md_op,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_start,
   output logic        md_busy,
   output logic        md_done,
   output logic        stall_D
);

   localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CB      = $clog2(MAX_LAT + 1);
   localparam int CW      = (CB > 4) ? CB : 4;

   localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;

   logic idle;
   logic op_mul;
   logic op_div;
   logic op_mt;
   logic issue;
   logic mt_pass;
   logic last;

   assign idle    = (state_q == IDLE);
   assign op_mul  = E_valid && (E_md_op == 4'd1 || E_md_op == 4'd2);
   assign op_div  = E_valid && (E_md_op == 4'd3 || E_md_op == 4'd4);
   assign op_mt   = E_valid && (E_md_op == 4'd5 || E_md_op == 4'd6);
   assign issue   = idle && (op_mul || op_div);
   assign mt_pass = idle && op_mt;

   always_comb begin
      last = 1'b0;
      unique case (state_q)
         MUL:     last = (cnt_q == MUL_LAT);
         DIV:     last = (cnt_q == DIV_LAT);
         default: last = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   // Busy-state requests from E are dropped: latched values stay put.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = op_mul ? MUL : DIV;
               cnt_d   = CNT_ONE;
               op_d    = E_md_op;
               a_d     = E_a;
               b_d     = E_b;
            end
         end
         MUL, DIV: begin
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      md_op    = 4'd0;
      md_a     = 32'd0;
      md_b     = 32'd0;
      md_start = 1'b0;
      unique case (1'b1)
         !idle: begin
            md_op = op_q;
            md_a  = a_q;
            md_b  = b_q;
         end
         issue: begin
            md_op    = E_md_op;
            md_a     = E_a;
            md_b     = E_b;
            md_start = 1'b1;
         end
         mt_pass: begin
            md_op = E_md_op;
            md_a  = E_a;
         end
         default: ;
      endcase
   end

   assign md_busy = (cnt_q != '0);
   assign md_done = last;
   assign stall_D = D_md_use && (md_start || md_busy);

endmodule

// File: doc/md_seq_ctrl.md
# md_seq_ctrl

Sequencing controller in front of the multiply/divide unit, living at the E stage of the five-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo requests from E and launches them on the unit.
- Holds op and operands stable for the full fixed latency of the operation.
- Tracks busy time with its own counter and raises the D-stage stall for any HI/LO-class instruction while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after issue for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles after issue for div/divu (must be ≥1)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- E_valid  in  1  E stage holds a real (non-bubble) instruction
- E_md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–15 treated as 0
- E_a, E_b  in  32  E-stage rs/rt forwarded values
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- md_op  out  4  op driven to the mul/div unit
- md_a, md_b  out  32  operands driven to the unit
- md_start  out  1  issue cycle of a mult/div (combinational)
- md_busy  out  1  unit occupied (registered counter ≠ 0)
- md_done  out  1  last busy cycle; HI/LO commit at the end of it
- stall_D  out  1  freeze F/D, bubble into E

## Operation
- States: IDLE, MUL, DIV. Counter cnt is 4 bits; for larger latencies it is widened to hold max(MULT_CYCLES, DIV_CYCLES).
- IDLE, E_valid=1, E_md_op ∈ {1..4}:
  - md_start=1 this cycle.
  - md_op/md_a/md_b pass through E_md_op/E_a/E_b combinationally.
  - At the edge: latch op_r/a_r/b_r, set cnt=1, go to MUL (ops 1,2) or DIV (ops 3,4).
- IDLE, E_valid=1, E_md_op ∈ {5,6}:
  - Pass through md_op/md_a for this cycle only.
  - No state change; md_busy and md_start stay 0.
- IDLE otherwise: md_op=0, md_a=md_b=0.
- MUL/DIV:
  - md_op=op_r, md_a=a_r, md_b=b_r; E inputs are ignored.
  - cnt increments each edge.
  - md_done=1 when cnt==LAT (LAT = MULT_CYCLES or DIV_CYCLES); at that edge cnt←0, state←IDLE.
- md_busy = (cnt≠0).
- stall_D = D_md_use & (md_start | md_busy).
- A mult/div op in E while busy cannot occur because stall_D prevents it. If one is presented anyway it is ignored: no relaunch, latched op/operands unchanged.
- Operand width rule: operands are latched as raw 32-bit values; signedness is carried only by op_r.

## Timing
- Reset (synchronous): next edge gives state=IDLE, cnt=0, op_r=0, a_r=b_r=0. Registered outputs are then 0: md_busy=0, md_done=0. md_op/md_a/md_b/md_start/stall_D are combinational; they read 0 only while inputs decode to IDLE-no-issue (E_valid=0 or E_md_op ∉ {1..6}).
- Reset mid-operation aborts it: no md_done pulse, counter cleared, stall released the cycle after reset is sampled.
- Latency, mult issued in cycle t:
  - md_start at t.
  - md_busy t+1..t+5.
  - md_done at t+5.
  - Idle at t+6.
- Latency, div issued in cycle t: md_busy t+1..t+10, md_done at t+10.
- stall_D is high for t..t+LAT when D_md_use=1. The D instruction advances at the edge ending t+LAT+1 and is in E at t+LAT+2.
- Back-to-back mult→mflo: mflo is stalled t..t+5 and reaches E at t+7, seeing the committed LO.
- D_md_use=0 never stalls, even while busy (non-MD instructions overlap freely).
- md_done and md_busy are both 1 in the final busy cycle.

## Test plan
- Reset, then E_valid=1, E_md_op=1, E_a=0xFFFFFFFE, E_b=3 at cycle 2 -> md_start=1 at cycle 2; md_busy cycles 3–7; md_done only at cycle 7; md_op=1, md_a=0xFFFFFFFE held throughout.
- divu (op 4), E_a=100, E_b=7; E_a changed to 0 on the next cycle -> md_a stays 100 for cycles 1–10; md_done at cnt=10; md_busy=0 the cycle after.
- mult issue with D_md_use=1 (mflo in D) -> stall_D=1 from the issue cycle through md_done; low the next cycle; D_md_use=0 variant gives stall_D=0 throughout.
- mthi (op 5), E_a=0x1234 while idle -> md_op=5, md_a=0x1234 for one cycle; md_busy=0, md_start=0, no stall.
- Assert reset at cnt=4 of a div -> cnt=0, md_busy=0 next cycle; md_done never pulses; a new mult is accepted right after.
- Force E_md_op=3 while in MUL at cnt=2 -> ignored: md_op stays 1, md_done still at cnt=5, no second launch.
